fifo: RTL and testbench
=======================

// Module: fifo
// PURPOSE
//  Synchronous single-clock FIFO buffering byte-wide data between a producer and a consumer.
//  The producer pushes with wr, and the consumer pops with en; read data is registered.
//  full and empty flags provide flow control.
//  It is a general-purpose storage element for datapath rate decoupling.
// PARAMETERS
//  DATA_WIDTH  8   width of data_in/data_out
//  DEPTH       16  number of storage entries (power of two)
//  ADDR_WIDTH  4   log2(DEPTH); pointer width (pointers carry one extra wrap bit)
// PORTS
//  clk       in   1           clock; all state updates on rising edge
//  rst       in   1           reset, synchronous, active-low (rst==0 at posedge clk resets)
//  wr        in   1           write request; push data_in when accepted
//  en        in   1           read enable; pop head entry when accepted
//  data_in   in   DATA_WIDTH  write data, sampled at posedge when write is accepted
//  data_out  out  DATA_WIDTH  registered read data
//  full      out  1           1 when DEPTH entries are stored
//  empty     out  1           1 when no entries are stored
// BEHAVIOUR
//  - Reset (rst==0 at posedge) has priority over wr/en.
//    - wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0.
//    - Storage array is not cleared.
//  - Write accept = wr & (~full | rd_accept).
//    - mem[wr_ptr]<=data_in; wr_ptr increments.
//  - Read accept = en & ~empty.
//    - data_out<=mem[rd_ptr], valid the cycle after the accepting edge (1-cycle latency); rd_ptr increments.
//  - data_out holds its last value when no read is accepted, including en while empty.
//  - Write while full without a simultaneous read: dropped; memory, pointers and flags unchanged.
//  - Read while empty: ignored. There is no fall-through, even with a simultaneous write.
//    - The write is still accepted; empty deasserts next cycle.
//  - Simultaneous accepted read+write: count unchanged; full/empty unchanged.
//    - When full, the read frees the slot and the write is accepted.
//  - Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH; address = low ADDR_WIDTH bits.
//    - full  = (wr_ptr[MSB]!=rd_ptr[MSB]) && (low bits equal).
//    - empty = (wr_ptr==rd_ptr).
//  - full and empty are combinational from the registered pointers.
//    - They reflect state after the last edge and are never both 1.
//  - Data order is strictly first-in-first-out across pointer wrap-around.
//  - Reset asserted mid-operation discards all contents on that edge.
//    - The first read after reset returns the first post-reset write.
//  - wr/en levels are sampled each cycle; holding en high pops one entry per cycle until empty.
// TESTING
//  1 rst=0 one cycle, then 1 -> empty=1, full=0, data_out=0.
//  2 write 8'hAA, 8'hCC, 8'h55 (one per cycle), then en=1 three cycles.
//    -> data_out AA, CC, 55 on successive cycles after each read edge; empty=1 after third.
//  3 write 16 values 0..15 -> full=1 after 16th.
//    - 17th write 8'hFF dropped.
//    - 16 reads return 0..15; FF never appears.
//  4 en=1 while empty with data_out=8'h55 -> data_out stays 55; pointers unchanged; empty=1.
//  5 wrap: write/read 24 entries in interleaved bursts of 5 -> output order matches input order.
//  6 full with wr=1,en=1 in the same cycle -> head popped, new byte stored, full stays 1.
//    - Empty with wr=1,en=1 -> write only, empty=0 next cycle.
//    - Mid-op reset -> empty=1, data_out=0.

Source files
------------

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and full/empty flags.
// The pointers carry one extra wrap bit, so full and empty come straight from comparing them.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_full;
  logic w_empty;
  logic w_rd_accept;
  logic w_wr_accept;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

  // A read in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign w_rd_accept = en & ~w_empty;
  assign w_wr_accept = wr & (~w_full | w_rd_accept);

  // NOTE: storage has no reset; the pointers alone decide which entries are valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  // NOTE: every register here uses <=, so all of them update from the values
  // they held before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic.
// Each result is compared against a queue-based reference model.
module tb_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout = '0;

  fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .wr(wr), .en(en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and advance the model; the outputs are sampled 1 ns after the edge.
  task automatic tick(input logic w, input logic e, input logic [7:0] d);
    bit rd_acc, wr_acc;
    @(negedge clk);
    rst = 1'b1; wr = w; en = e; data_in = d;
    rd_acc = e && (q.size() != 0);
    wr_acc = w && ((q.size() < DEPTH) || rd_acc);
    @(posedge clk);
    if (rd_acc) m_dout = q.pop_front();
    if (wr_acc) q.push_back(d);
    #1;
  endtask

  // Reset is applied with wr and en both high, so it must take priority over them.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; wr = 1'b1; en = 1'b1; data_in = 8'h99;
    @(posedge clk);
    q.delete();
    m_dout = '0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tick(1'b0, 1'b0, 8'h00);
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: empty=%b full=%b data_out=%h, expected empty=1 full=0 data_out=00",
               empty, full, data_out);
    end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3] = '{8'hAA, 8'hCC, 8'h55};
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, vals[i]);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      vectors++;
      if (data_out !== vals[i] || empty !== (i == 2)) begin
        miscompares++;
        $display("FAIL basic[%0d]: data_out=%h empty=%b, expected %h empty=%b",
                 i, data_out, empty, vals[i], (i == 2));
      end
    end
  endtask

  task automatic test_read_empty();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      vectors++;
      if (data_out !== 8'h55 || empty !== 1'b1 || full !== 1'b0) begin
        miscompares++;
        $display("FAIL read_empty: data_out=%h empty=%b full=%b, expected 55 1 0",
                 data_out, empty, full);
      end
    end
    // If the pointers had moved, the next write would not come back as the head.
    tick(1'b1, 1'b0, 8'h3A);
    tick(1'b0, 1'b1, 8'h00);
    vectors++;
    if (data_out !== 8'h3A || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL read_empty_ptr: data_out=%h empty=%b, expected 3a 1", data_out, empty);
    end
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 8'(i));
      vectors++;
      if (full !== (i == DEPTH - 1) || empty !== 1'b0) begin
        miscompares++;
        $display("FAIL fill[%0d]: full=%b empty=%b, expected full=%b empty=0",
                 i, full, empty, (i == DEPTH - 1));
      end
    end
    tick(1'b1, 1'b0, 8'hFF);
    vectors++;
    if (full !== 1'b1 || q.size() != DEPTH) begin
      miscompares++;
      $display("FAIL drop: full=%b, expected 1", full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      vectors++;
      if (data_out !== 8'(i) || empty !== (i == DEPTH - 1) || full !== 1'b0) begin
        miscompares++;
        $display("FAIL drain[%0d]: data_out=%h empty=%b full=%b, expected %h empty=%b full=0",
                 i, data_out, empty, full, 8'(i), (i == DEPTH - 1));
      end
    end
  endtask

  task automatic test_wrap();
    int written = 0;
    int read = 0;
    logic [7:0] sent [24];
    for (int i = 0; i < 24; i++) sent[i] = 8'($urandom);
    while (read < 24) begin
      for (int k = 0; k < 5 && written < 24; k++) begin
        tick(1'b1, 1'b0, sent[written]);
        written++;
      end
      for (int k = 0; k < 5 && read < written; k++) begin
        tick(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_out !== sent[read]) begin
          miscompares++;
          $display("FAIL wrap[%0d]: data_out=%h, expected %h", read, data_out, sent[read]);
        end
        read++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] head;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 8'(8'h40 + i));
    head = q[0];
    tick(1'b1, 1'b1, 8'hE7);
    vectors++;
    if (data_out !== head || full !== 1'b1 || q[DEPTH-1] !== 8'hE7) begin
      miscompares++;
      $display("FAIL full_rw: data_out=%h full=%b, expected %h full=1", data_out, full, head);
    end
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 8'h00);
    vectors++;
    if (data_out !== 8'hE7 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_rw_tail: data_out=%h empty=%b, expected e7 1", data_out, empty);
    end
    // No fall-through: a read while empty must leave data_out alone even with a write in the same cycle.
    tick(1'b1, 1'b1, 8'h5B);
    vectors++;
    if (empty !== 1'b0 || data_out !== 8'hE7) begin
      miscompares++;
      $display("FAIL empty_rw: empty=%b data_out=%h, expected empty=0 data_out=e7", empty, data_out);
    end
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'(8'h70 + i));
    tick(1'b0, 1'b1, 8'h00);
    apply_reset();
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midop_reset: empty=%b full=%b data_out=%h, expected 1 0 00",
               empty, full, data_out);
    end
    tick(1'b1, 1'b0, 8'h3C);
    tick(1'b0, 1'b1, 8'h00);
    vectors++;
    if (data_out !== 8'h3C || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_read: data_out=%h empty=%b, expected 3c 1", data_out, empty);
    end
  endtask

  task automatic test_random();
    logic w, e;
    for (int i = 0; i < 400; i++) begin
      // The write bias shifts every 100 cycles so the queue spends time both near full and near empty.
      w = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 70 : 30));
      e = ($urandom_range(99) < 50);
      tick(w, e, 8'($urandom));
      vectors++;
      if (data_out !== m_dout || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        miscompares++;
        $display("FAIL random[%0d]: data_out=%h full=%b empty=%b, expected %h %b %b",
                 i, data_out, full, empty, m_dout, (q.size() == DEPTH), (q.size() == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read_empty();
    test_full_drop();
    test_wrap();
    test_back_to_back();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
